alu_seq: RTL and testbench

- Multi-cycle ALU stage directly upstream of the accumulator; drives the accumulator's write_port/write_bit pair.
- Accepts an operation plus two operands: A comes from the accumulator read_port, B from the operand bus.
- Single-step ops finish in 1 cycle; MUL (shift-add) and DIV (restoring) iterate 8 cycles.
- Result is presented with a one-cycle write strobe.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/alu_iter_core.sv | 66 ++++++
 rtl/alu_seq.sv | 115 +++++++++++
 tb/tb_alu_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU stage: opcode values, FSM state encoding and
// the default datapath width.
package cpu_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_MUL   = 3'd5,
    OP_DIV   = 3'd6,
    OP_PASSB = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath shared by shift-add multiply and restoring divide.
// part holds the partial product / remainder, shift the multiplier / quotient.
module alu_iter_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] part_q, shift_q, divisor_q;
  logic [WIDTH-1:0] part_nxt, shift_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   mul_sum, div_trial;

  assign mul_sum   = {1'b0, part_q} + (shift_q[0] ? {1'b0, divisor_q} : '0);
  assign div_trial = {part_q, shift_q[WIDTH-1]};

  // NOTE: every output of a combinational block is assigned on all paths so no latch is inferred.
  always_comb begin
    {part_nxt, shift_nxt} = {mul_sum, shift_q[WIDTH-1:1]};
    if (is_div) begin
      if (div_trial >= {1'b0, divisor_q}) begin
        part_nxt  = div_trial[WIDTH-1:0] - divisor_q;
        shift_nxt = {shift_q[WIDTH-2:0], 1'b1};
      end else begin
        part_nxt  = div_trial[WIDTH-1:0];
        shift_nxt = {shift_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      part_q    <= '0;
      shift_q   <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
    end else if (load) begin
      part_q    <= '0;
      shift_q   <= a;
      divisor_q <= b;
      cnt_q     <= CNT_W'(WIDTH - 1);
    end else if (step) begin
      part_q  <= part_nxt;
      shift_q <= shift_nxt;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Results reflect the step in progress, so the last step's value is final.
  assign result_lo = shift_nxt;
  assign result_hi = part_nxt;
  assign done      = step && (cnt_q == '0);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU stage feeding the accumulator write port: single-cycle
// logic/add ops, WIDTH-iteration MUL/DIV, one-cycle write strobe.
module alu_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             acc_we,
  output logic [WIDTH-1:0] acc_wdata,
  output logic             flag_z,
  output logic             flag_c,
  output logic             div_zero
);

  state_t           state, state_nxt;
  op_t              op_in, op_q;
  logic             accept, single_step, wr_en, wr_c, wr_dz;
  logic             ss_c, ss_dz, core_done;
  logic [WIDTH-1:0] ss_data, wr_data, core_lo, core_hi;
  logic [WIDTH:0]   add_ext, sub_ext;

  assign op_in       = op_t'(op);
  assign accept      = (state == S_IDLE) && start;
  assign single_step = !((op_in == OP_MUL) || ((op_in == OP_DIV) && (b_in != '0)));

  assign add_ext = {1'b0, a_in} + {1'b0, b_in};
  assign sub_ext = {1'b0, a_in} - {1'b0, b_in};

  always_comb begin
    ss_data = '0;
    ss_c    = 1'b0;
    ss_dz   = 1'b0;
    case (op_in)
      OP_ADD:   {ss_c, ss_data} = add_ext;
      OP_SUB:   {ss_c, ss_data} = sub_ext;
      OP_AND:   ss_data = a_in & b_in;
      OP_OR:    ss_data = a_in | b_in;
      OP_XOR:   ss_data = a_in ^ b_in;
      OP_MUL:   ss_data = '0;
      OP_DIV: begin
        // Only reached on the single-step path, i.e. divide by zero.
        ss_data = '1;
        ss_dz   = 1'b1;
      end
      OP_PASSB: ss_data = b_in;
      default:  ss_data = '0;
    endcase
  end

  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && !single_step),
    .step      (state == S_EXEC),
    .is_div    (op_q == OP_DIV),
    .a         (a_in),
    .b         (b_in),
    .result_lo (core_lo),
    .result_hi (core_hi),
    .done      (core_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = single_step ? S_WRITE : S_EXEC;
      S_EXEC:  if (core_done) state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != S_IDLE);
    acc_we = (state == S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst)         op_q <= OP_ADD;
    else if (accept) op_q <= op_in;
  end

  // Results are registered on the edge that enters WRITE and then held.
  assign wr_en   = (accept && single_step) || ((state == S_EXEC) && core_done);
  assign wr_data = (state == S_EXEC) ? core_lo : ss_data;
  assign wr_c    = (state == S_EXEC) ? (core_hi != '0) : ss_c;
  assign wr_dz   = (state == S_EXEC) ? 1'b0 : ss_dz;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_wdata <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      div_zero  <= 1'b0;
    end else if (wr_en) begin
      acc_wdata <= wr_data;
      flag_z    <= (wr_data == '0);
      flag_c    <= wr_c;
      div_zero  <= wr_dz;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected writes, a monitor
// pops and compares them whenever acc_we is seen.
module tb_alu_seq;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] a_in = 8'h00, b_in = 8'h00;
  logic       busy, acc_we, flag_z, flag_c, div_zero;
  logic [7:0] acc_wdata;

  typedef struct {
    logic [7:0] data;
    logic       c, z, dz;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .acc_we    (acc_we),
    .acc_wdata (acc_wdata),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (acc_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_we", 32'(acc_we), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wdata", 32'(acc_wdata), 32'(e.data));
        check("flag_c", 32'(flag_c), 32'(e.c));
        check("flag_z", 32'(flag_z), 32'(e.z));
        check("div_zero", 32'(div_zero), 32'(e.dz));
        check("we_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  // Inputs are scrambled after accept to show that operands were latched.
  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic ec, input logic ez,
                       input logic edz, input int lat, input bit pulse);
    exp_t e;
    @(posedge clk); #1;
    e.data = ed; e.c = ec; e.z = ez; e.dz = edz; e.cyc = cyc + lat;
    sb.push_back(e);
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = OP_PASSB; a_in = ~a; b_in = ~b;
    if (pulse) begin
      repeat (2) @(posedge clk);
      #1; start = 1'b1; op = OP_ADD;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(acc_we), 32'd0);
    check("rst_wdata", 32'(acc_wdata), 32'h00);
    check("rst_flags", {29'd0, flag_z, flag_c, div_zero}, 32'd0);
    repeat (10) @(posedge clk);

    // ADD with carry; start held through WRITE must not start a second op.
    @(posedge clk); #1;
    k = cyc;
    sb.push_back('{data: 8'h10, c: 1'b1, z: 1'b0, dz: 1'b0, cyc: k + 1});
    op = OP_ADD; a_in = 8'hF0; b_in = 8'h20; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("add_busy_n1", 32'(busy), 32'd1);
    @(negedge clk);
    check("add_busy_n2", 32'(busy), 32'd0);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("hold_wdata", 32'(acc_wdata), 32'h10);
    check("hold_flag_c", 32'(flag_c), 32'd1);

    issue(OP_SUB,   8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    issue(OP_SUB,   8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    issue(OP_AND,   8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    issue(OP_OR,    8'h0C, 8'h30, 8'h3C, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    issue(OP_XOR,   8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    issue(OP_PASSB, 8'h11, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    issue(OP_MUL,   8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 1'b0, 9, 1'b0);
    issue(OP_MUL,   8'h20, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0, 9, 1'b1);
    issue(OP_MUL,   8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 9, 1'b0);
    issue(OP_DIV,   8'h64, 8'h07, 8'h0E, 1'b1, 1'b0, 1'b0, 9, 1'b0);
    issue(OP_DIV,   8'h42, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    issue(OP_DIV,   8'h90, 8'h0C, 8'h0C, 1'b0, 1'b0, 1'b0, 9, 1'b1);

    // Reset during a MUL: no strobe may ever appear for it.
    @(posedge clk); #1;
    op = OP_MUL; a_in = 8'h0D; b_in = 8'h0B; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_we", 32'(acc_we), 32'd0);
    check("abort_wdata", 32'(acc_wdata), 32'h00);
    check("abort_flags", {29'd0, flag_z, flag_c, div_zero}, 32'd0);
    repeat (12) @(posedge clk);
    issue(OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
